// File: rtl/pos_cell_reader_if.sv
// ---------------------------------------------------------------------------
// pos_cell_reader_if
//
// Bundles every non-clock/reset signal of the per-cell position reader:
//   control : start (in), busy / done / particle_count / count_err (out)
//   RAM bus : mem_address / mem_rden / mem_wren (out), mem_q (in)
//   stream  : out_data / out_id / out_valid / out_last (out), out_ready (in)
//
// The "master" modport is the reader itself (it masters the RAM read port
// and sources the position stream). The "slave" modport is the environment
// around it: the controller issuing start, the cell RAM and the downstream
// position-cache consumer.
// ---------------------------------------------------------------------------
interface pos_cell_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] particle_count;
  logic                  count_err;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;

  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_id;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    input  start,
    input  mem_q,
    input  out_ready,
    output busy,
    output done,
    output particle_count,
    output count_err,
    output mem_address,
    output mem_rden,
    output mem_wren,
    output out_data,
    output out_id,
    output out_valid,
    output out_last
  );

  modport slave (
    output start,
    output mem_q,
    output out_ready,
    input  busy,
    input  done,
    input  particle_count,
    input  count_err,
    input  mem_address,
    input  mem_rden,
    input  mem_wren,
    input  out_data,
    input  out_id,
    input  out_valid,
    input  out_last
  );

endinterface

// File: rtl/pos_cell_reader.sv
// ---------------------------------------------------------------------------
// pos_cell_reader
//
// Streaming read controller for one per-cell position RAM. On start it reads
// address 0 to obtain the particle count N (clamped to PARTICLE_NUM-1), then
// reads addresses 1..N and delivers each {posz, posy, posx} word on a
// valid/ready stream tagged with its RAM address.
//
// Ports:
//   clk  : single rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pos_cell_reader_if.master
//          start / busy / done / particle_count / count_err  - pass control
//          mem_address / mem_rden / mem_wren / mem_q          - RAM read port
//          out_data / out_id / out_valid / out_ready / out_last - word stream
//
// The RAM returns data two cycles after the mem_rden cycle. A two-stage
// tracker follows each particle read through that latency and, when it
// emerges, writes {mem_q, address} into a 4-entry FIFO whose head drives the
// stream. Reads are only issued while FIFO occupancy plus reads in flight
// stays below 4, so the FIFO can never overflow even under full backpressure.
// ---------------------------------------------------------------------------
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic               clk,
  input  logic               rst,
  pos_cell_reader_if.master  bus
);

  localparam int FIFO_DEPTH = 4;
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CNT,
    ST_WAIT_CNT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // ------------------------------------------------------------------------
  // State and output registers
  // ------------------------------------------------------------------------
  state_t                state_q,          state_d;
  logic                  busy_q,           busy_d;
  logic                  done_q,           done_d;
  logic                  count_err_q,      count_err_d;
  logic [ADDR_WIDTH-1:0] particle_count_q, particle_count_d;
  logic [ADDR_WIDTH-1:0] mem_address_q,    mem_address_d;
  logic                  mem_rden_q,       mem_rden_d;
  logic                  wait_q,           wait_d;
  // One bit wider than the address so that N+1 never wraps.
  logic [ADDR_WIDTH:0]   next_addr_q,      next_addr_d;

  // Latency tracker: stage 1 is one cycle after the read, stage 2 lines up
  // with the cycle in which mem_q carries that read's data.
  logic                  trk1_valid_q,     trk1_valid_d;
  logic [ADDR_WIDTH-1:0] trk1_addr_q,      trk1_addr_d;
  logic                  trk2_valid_q,     trk2_valid_d;
  logic [ADDR_WIDTH-1:0] trk2_addr_q,      trk2_addr_d;

  // Output FIFO
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_id_q   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_id_d   [FIFO_DEPTH];
  logic [1:0]            wr_ptr_q,         wr_ptr_d;
  logic [1:0]            rd_ptr_q,         rd_ptr_d;
  logic [2:0]            fifo_count_q,     fifo_count_d;

  // ------------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------------
  logic                  out_valid_w;
  logic [ADDR_WIDTH-1:0] out_id_w;
  logic                  out_last_w;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  trk_in;
  logic [3:0]            occ_next;
  logic [3:0]            credit_used;
  logic                  can_issue;
  logic [ADDR_WIDTH-1:0] raw_count;
  logic                  count_over;
  logic [ADDR_WIDTH-1:0] clamped_count;

  // Stream head, handshake and the read-credit computation.
  // Credit looks at the state the pipeline will be in after this edge: the
  // FIFO after this cycle's push/pop, plus the read on the bus now and the
  // one in tracker stage 1 (those two become stages 1 and 2 next cycle).
  // Counting this cycle's pop lets issue resume the cycle right after a pop.
  always_comb begin
    out_valid_w   = (fifo_count_q != 3'd0);
    out_id_w      = fifo_id_q[rd_ptr_q];
    out_last_w    = out_valid_w && (out_id_w == particle_count_q);
    fifo_pop      = out_valid_w && bus.out_ready;
    fifo_push     = trk2_valid_q;
    trk_in        = mem_rden_q && (state_q == ST_STREAM);
    occ_next      = {1'b0, fifo_count_q} + {3'b000, fifo_push} - {3'b000, fifo_pop};
    credit_used   = occ_next + {3'b000, trk_in} + {3'b000, trk1_valid_q};
    can_issue     = (credit_used < 4'(FIFO_DEPTH));
    raw_count     = bus.mem_q[ADDR_WIDTH-1:0];
    count_over    = (raw_count > MAX_COUNT);
    clamped_count = count_over ? MAX_COUNT : raw_count;
  end

  // Tracker and FIFO next-state. The count read in RD_CNT is deliberately
  // not tracked, so only particle words ever reach the FIFO.
  always_comb begin
    trk1_valid_d = trk_in;
    trk1_addr_d  = mem_address_q;
    trk2_valid_d = trk1_valid_q;
    trk2_addr_d  = trk1_addr_q;

    fifo_data_d  = fifo_data_q;
    fifo_id_d    = fifo_id_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;

    if (fifo_push) begin
      fifo_data_d[wr_ptr_q] = bus.mem_q;
      fifo_id_d[wr_ptr_q]   = trk2_addr_q;
      wr_ptr_d              = wr_ptr_q + 2'd1;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    fifo_count_d = fifo_count_q + {2'b00, fifo_push} - {2'b00, fifo_pop};
  end

  // Pass sequencer. All of busy/done/mem_rden/mem_address are computed one
  // cycle ahead so they leave the block straight from flops. The first
  // particle read is launched from the last WAIT_CNT cycle, when the tracker
  // is known to be empty, so it lands in the first STREAM cycle.
  always_comb begin
    state_d          = state_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    count_err_d      = count_err_q;
    particle_count_d = particle_count_q;
    mem_address_d    = mem_address_q;
    mem_rden_d       = 1'b0;
    wait_d           = wait_q;
    next_addr_d      = next_addr_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d       = ST_RD_CNT;
          busy_d        = 1'b1;
          count_err_d   = 1'b0;
          mem_rden_d    = 1'b1;
          mem_address_d = '0;
        end
      end

      ST_RD_CNT: begin
        state_d = ST_WAIT_CNT;
        wait_d  = 1'b0;
      end

      ST_WAIT_CNT: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          particle_count_d = clamped_count;
          count_err_d      = count_over;
          if (clamped_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d       = ST_STREAM;
            mem_rden_d    = 1'b1;
            mem_address_d = ADDR_WIDTH'(1);
            next_addr_d   = (ADDR_WIDTH+1)'(2);
          end
        end
      end

      // next_addr beyond N means address N is on the bus this cycle, so the
      // last read has gone out and only the drain remains.
      ST_STREAM: begin
        if (next_addr_q > {1'b0, particle_count_q}) begin
          state_d = ST_DRAIN;
        end else if (can_issue) begin
          mem_rden_d    = 1'b1;
          mem_address_d = next_addr_q[ADDR_WIDTH-1:0];
          next_addr_d   = next_addr_q + (ADDR_WIDTH+1)'(1);
        end
      end

      ST_DRAIN: begin
        if (fifo_pop && out_last_w) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Register bank. Reset also flushes the tracker, so RAM data still
  // returning from reads issued before the reset is simply never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      count_err_q      <= 1'b0;
      particle_count_q <= '0;
      mem_address_q    <= '0;
      mem_rden_q       <= 1'b0;
      wait_q           <= 1'b0;
      next_addr_q      <= '0;
      trk1_valid_q     <= 1'b0;
      trk1_addr_q      <= '0;
      trk2_valid_q     <= 1'b0;
      trk2_addr_q      <= '0;
      fifo_data_q      <= '{default: '0};
      fifo_id_q        <= '{default: '0};
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      fifo_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      count_err_q      <= count_err_d;
      particle_count_q <= particle_count_d;
      mem_address_q    <= mem_address_d;
      mem_rden_q       <= mem_rden_d;
      wait_q           <= wait_d;
      next_addr_q      <= next_addr_d;
      trk1_valid_q     <= trk1_valid_d;
      trk1_addr_q      <= trk1_addr_d;
      trk2_valid_q     <= trk2_valid_d;
      trk2_addr_q      <= trk2_addr_d;
      fifo_data_q      <= fifo_data_d;
      fifo_id_q        <= fifo_id_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      fifo_count_q     <= fifo_count_d;
    end
  end

  // The credit rule must keep a push from ever landing on a full FIFO
  // unless a pop frees the slot in the same cycle.
  assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && !fifo_pop && (fifo_count_q == 3'(FIFO_DEPTH))));

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.count_err      = count_err_q;
  assign bus.particle_count = particle_count_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_rden       = mem_rden_q;
  assign bus.mem_wren       = 1'b0;
  assign bus.out_data       = fifo_data_q[rd_ptr_q];
  assign bus.out_id         = out_id_w;
  assign bus.out_valid      = out_valid_w;
  assign bus.out_last       = out_last_w;

endmodule
